mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 100 ++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: bridges the pipeline MEM stage to a fixed-latency
// synchronous RAM. Writes complete in one cycle; reads stall the pipeline
// for LATENCY+1 cycles and return data through a holding register.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_dout,
    output logic [31:0]           mem_din,
    output logic                  mem_stall,
    output logic                  addr_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    // Counter holds values up to 7, the largest legal LATENCY.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             rdata_q;

    logic                    in_idle;
    logic                    bad_addr;
    logic                    do_write;
    logic                    do_read;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign word_addr = mem_addr[ADDR_WIDTH+1:2];
    assign bad_addr  = (mem_addr[1:0] != 2'b00) ||
                       ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // Request decode and RAM-side drive; only IDLE accepts requests, write wins over read.
    always_comb begin
        in_idle   = rst_n && (state == IDLE);
        do_write  = in_idle && mem_wen && !bad_addr;
        do_read   = in_idle && mem_ren && !mem_wen && !bad_addr;
        addr_err  = in_idle && (mem_ren || mem_wen) && bad_addr;
        ram_en    = do_write || do_read;
        ram_we    = do_write;
        mem_stall = do_read || (rst_n && (state == BUSY));
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n) begin
            ram_addr  = (state == IDLE) ? word_addr : addr_q;
            ram_wdata = mem_dout;
        end
    end

    // Read sequencer: issue in IDLE, count down latency in BUSY, release stall in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_read) begin
                        state  <= BUSY;
                        cnt    <= CNT_W'(LATENCY);
                        addr_q <= word_addr;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rdata_q <= ram_rdata;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_din = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: three instances with LATENCY 2, 1
// and 7, each against a RAM model that presents read data only in the cycle
// exactly LATENCY cycles after the issuing cycle.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ren       [3];
    logic        wen       [3];
    logic [31:0] addr      [3];
    logic [31:0] dout      [3];
    logic [31:0] mem_din   [3];
    logic        mem_stall [3];
    logic        addr_err  [3];
    logic        ram_en    [3];
    logic        ram_we    [3];
    logic [9:0]  ram_addr  [3];
    logic [31:0] ram_wdata [3];
    logic [31:0] ram_rdata [3];

    logic [31:0] mem    [3][1024];
    logic [9:0]  rd_addr[3];
    int          age    [3];
    int          lat_of [3];

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .mem_ren(ren[0]), .mem_wen(wen[0]),
        .mem_addr(addr[0]), .mem_dout(dout[0]), .mem_din(mem_din[0]),
        .mem_stall(mem_stall[0]), .addr_err(addr_err[0]), .ram_en(ram_en[0]),
        .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_rdata(ram_rdata[0]));

    mem_access_unit #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_ren(ren[1]), .mem_wen(wen[1]),
        .mem_addr(addr[1]), .mem_dout(dout[1]), .mem_din(mem_din[1]),
        .mem_stall(mem_stall[1]), .addr_err(addr_err[1]), .ram_en(ram_en[1]),
        .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_rdata(ram_rdata[1]));

    mem_access_unit #(.ADDR_WIDTH(10), .LATENCY(7)) u_l7 (
        .clk(clk), .rst_n(rst_n), .mem_ren(ren[2]), .mem_wen(wen[2]),
        .mem_addr(addr[2]), .mem_dout(dout[2]), .mem_din(mem_din[2]),
        .mem_stall(mem_stall[2]), .addr_err(addr_err[2]), .ram_en(ram_en[2]),
        .ram_we(ram_we[2]), .ram_addr(ram_addr[2]), .ram_wdata(ram_wdata[2]),
        .ram_rdata(ram_rdata[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: writes land at the edge; a read's data is valid only LATENCY cycles after issue.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_en[k] && ram_we[k]) mem[k][ram_addr[k]] <= ram_wdata[k];
            if (ram_en[k] && !ram_we[k]) begin
                rd_addr[k] <= ram_addr[k];
                age[k]     <= 1;
            end else if (age[k] < 15) begin
                age[k] <= age[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ram_rdata[k] = (age[k] == lat_of[k]) ? mem[k][rd_addr[k]] : 32'hBAD0_BAD0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
        ren[k] = 1'b0; wen[k] = 1'b1; addr[k] = a; dout[k] = d;
        #1;
        chk("wr_en",    32'(ram_en[k]),    32'd1);
        chk("wr_we",    32'(ram_we[k]),    32'd1);
        chk("wr_stall", 32'(mem_stall[k]), 32'd0);
        next_cycle();
        wen[k] = 1'b0;
    endtask

    // Issue a read and count stall cycles until the DONE cycle; request stays high through DONE.
    task automatic do_read(input int k, input logic [31:0] a, input int lat, input logic [31:0] exp);
        int n;
        int ens;
        logic [31:0] wa;
        wa = 32'(a[11:2]);
        ren[k] = 1'b1; wen[k] = 1'b0; addr[k] = a;
        #1;
        chk("rd_issue_addr", 32'(ram_addr[k]), wa);
        chk("rd_issue_we",   32'(ram_we[k]),   32'd0);
        n = 0;
        ens = 0;
        while (mem_stall[k] && n < 20) begin
            n++;
            if (ram_en[k]) ens++;
            next_cycle();
        end
        chk("rd_stall_cycles", 32'(n),        32'(lat + 1));
        chk("rd_en_pulses",    32'(ens),      32'd1);
        chk("rd_done_no_en",   32'(ram_en[k]), 32'd0);
        chk("rd_data",         mem_din[k],    exp);
        next_cycle();
        ren[k] = 1'b0;
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dout;
        logic        en;
        logic        we;
        logic [9:0]  raddr;
        logic        stall;
        logic        err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lat_of[0] = 2; lat_of[1] = 1; lat_of[2] = 7;

        // ren, wen, addr, dout, exp en, we, word addr, stall, err
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 10'h004, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 10'h004, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b1, 1'b1, 10'h002, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_1002, 32'h5555_5555, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h6666_6666, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b0, 10'h000, 1'b0, 1'b0};

        // Reset with requests asserted: everything must stay quiet.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ren[k] = 1'b1; wen[k] = 1'b1; addr[k] = 32'h10; dout[k] = 32'hFFFF_FFFF;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_en",    32'(ram_en[k]),    32'd0);
            chk("rst_we",    32'(ram_we[k]),    32'd0);
            chk("rst_stall", 32'(mem_stall[k]), 32'd0);
            chk("rst_err",   32'(addr_err[k]),  32'd0);
            chk("rst_din",   mem_din[k],        32'd0);
            chk("rst_addr",  32'(ram_addr[k]),  32'd0);
            chk("rst_wdata", ram_wdata[k],      32'd0);
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = 32'h0; dout[k] = 32'h0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Single-cycle vectors on the LATENCY=2 instance: writes, errors, idle.
        for (int i = 0; i < NV; i++) begin
            ren[0] = vecs[i].ren; wen[0] = vecs[i].wen;
            addr[0] = vecs[i].addr; dout[0] = vecs[i].dout;
            #1;
            chk($sformatf("vec%0d_en", i),    32'(ram_en[0]),    32'(vecs[i].en));
            chk($sformatf("vec%0d_we", i),    32'(ram_we[0]),    32'(vecs[i].we));
            chk($sformatf("vec%0d_stall", i), 32'(mem_stall[0]), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_err", i),   32'(addr_err[0]),  32'(vecs[i].err));
            chk($sformatf("vec%0d_din", i),   mem_din[0],        32'd0);
            if (vecs[i].en) begin
                chk($sformatf("vec%0d_addr", i),  32'(ram_addr[0]), 32'(vecs[i].raddr));
                chk($sformatf("vec%0d_wdata", i), ram_wdata[0],     vecs[i].dout);
            end
            next_cycle();
        end
        ren[0] = 1'b0; wen[0] = 1'b0;

        // Cycle-by-cycle read of 0x10 with LATENCY=2.
        ren[0] = 1'b1; addr[0] = 32'h10;
        #1;
        chk("t0_en",    32'(ram_en[0]),    32'd1);
        chk("t0_we",    32'(ram_we[0]),    32'd0);
        chk("t0_addr",  32'(ram_addr[0]),  32'd4);
        chk("t0_stall", 32'(mem_stall[0]), 32'd1);
        next_cycle();
        chk("t1_stall", 32'(mem_stall[0]), 32'd1);
        chk("t1_en",    32'(ram_en[0]),    32'd0);
        next_cycle();
        chk("t2_stall", 32'(mem_stall[0]), 32'd1);
        chk("t2_en",    32'(ram_en[0]),    32'd0);
        next_cycle();
        chk("t3_stall", 32'(mem_stall[0]), 32'd0);
        chk("t3_en",    32'(ram_en[0]),    32'd0);
        chk("t3_din",   mem_din[0],        32'hDEAD_BEEF);
        ren[0] = 1'b0;
        next_cycle();
        chk("t4_din",   mem_din[0],        32'hDEAD_BEEF);

        do_read(0, 32'h8,   2, 32'hCAFE_F00D);
        do_read(0, 32'hFFC, 2, 32'h0BAD_C0DE);

        // Misaligned read after a completed read leaves mem_din alone.
        ren[0] = 1'b1; addr[0] = 32'h13;
        #1;
        chk("mis_err",   32'(addr_err[0]),  32'd1);
        chk("mis_stall", 32'(mem_stall[0]), 32'd0);
        chk("mis_en",    32'(ram_en[0]),    32'd0);
        next_cycle();
        chk("mis_stall2", 32'(mem_stall[0]), 32'd0);
        chk("mis_din",    mem_din[0],        32'h0BAD_C0DE);
        ren[0] = 1'b0;
        next_cycle();

        // Reset while BUSY abandons the read; a following read runs normally.
        ren[0] = 1'b1; addr[0] = 32'h8;
        next_cycle();
        chk("rb_busy_stall", 32'(mem_stall[0]), 32'd1);
        rst_n = 1'b0;
        ren[0] = 1'b0;
        #1;
        chk("rb_stall", 32'(mem_stall[0]), 32'd0);
        chk("rb_din",   mem_din[0],        32'd0);
        chk("rb_en",    32'(ram_en[0]),    32'd0);
        chk("rb_addr",  32'(ram_addr[0]),  32'd0);
        #1;
        rst_n = 1'b1;
        next_cycle();
        chk("rb_idle_stall", 32'(mem_stall[0]), 32'd0);
        chk("rb_idle_en",    32'(ram_en[0]),    32'd0);
        chk("rb_idle_din",   mem_din[0],        32'd0);
        do_read(0, 32'h10, 2, 32'hDEAD_BEEF);

        // LATENCY=1: back-to-back reads, request held high through DONE.
        do_write(1, 32'h0, 32'h0123_4567);
        do_write(1, 32'h4, 32'h89AB_CDEF);
        do_read(1, 32'h0, 1, 32'h0123_4567);
        do_read(1, 32'h4, 1, 32'h89AB_CDEF);

        // LATENCY=7: long stall; RAM data turns to garbage after the capture edge.
        do_write(2, 32'h40, 32'h7777_7777);
        do_read(2, 32'h40, 7, 32'h7777_7777);
        next_cycle();
        next_cycle();
        chk("l7_din_hold",   mem_din[2],        32'h7777_7777);
        chk("l7_rdata_junk", ram_rdata[2],      32'hBAD0_BAD0);
        chk("l7_idle_stall", 32'(mem_stall[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
